// File: rtl/urv_mult_seq_pkg.sv
// Shared types, widths and helpers for the sequential RV32M multiplier.
package urv_mult_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HALF  = 16;
  localparam int unsigned OPW   = 18;
  localparam int unsigned PRODW = 36;
  localparam int unsigned ACCW  = 64;

  // Left shift applied to partial product k before accumulation
  localparam int unsigned SHIFT_K0 = 0;
  localparam int unsigned SHIFT_K1 = 16;
  localparam int unsigned SHIFT_K2 = 16;
  localparam int unsigned SHIFT_K3 = 32;

  typedef enum logic [1:0] {
    FUN_MUL    = 2'b00,
    FUN_MULH   = 2'b01,
    FUN_MULHSU = 2'b10,
    FUN_MULHU  = 2'b11
  } fun_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  // Operation captured when a start is accepted
  typedef struct packed {
    fun_t             fun;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } mul_req_t;

  // Upper half of an operand widened to the multiplier input width
  function automatic logic [OPW-1:0] hi_ext(logic [XLEN-1:0] v, logic sgn);
    return {{(OPW-HALF){sgn & v[XLEN-1]}}, v[XLEN-1:HALF]};
  endfunction

  // Lower half of an operand, always unsigned
  function automatic logic [OPW-1:0] lo_ext(logic [XLEN-1:0] v);
    return {{(OPW-HALF){1'b0}}, v[HALF-1:0]};
  endfunction

  // Sign-extend a partial product and align it to its weight
  function automatic logic [ACCW-1:0] pp_align(logic [PRODW-1:0] p, logic [1:0] k);
    logic [ACCW-1:0] ext;
    ext = {{(ACCW-PRODW){p[PRODW-1]}}, p};
    case (k)
      2'd0:    return ext << SHIFT_K0;
      2'd1:    return ext << SHIFT_K1;
      2'd2:    return ext << SHIFT_K2;
      default: return ext << SHIFT_K3;
    endcase
  endfunction

endpackage

// File: rtl/urv_mult_seq_mult18x18.sv
// Registered 18x18 signed multiplier with clock enable (generic model of the platform primitive).
module urv_mult18x18 (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ce_i,
  input  logic signed [17:0] x_i,
  input  logic signed [17:0] y_i,
  output logic signed [35:0] q_o
);

  // Product register, frozen when ce_i is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (ce_i) begin
      q_o <= x_i * y_i;
    end
  end

endmodule

// File: rtl/urv_mult_seq.sv
// Sequential RV32M multiplier: four 18x18 partial products through one shared multiplier.
module urv_mult_seq
  import urv_mult_seq_pkg::*;
#(
  parameter int unsigned g_fast_mul_lo = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [1:0]  fun_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  mul_req_t          req_q, req_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              a_sgn, b_sgn;
  logic [OPW-1:0]    mx, my;
  logic [PRODW-1:0]  prod;
  logic [ACCW-1:0]   sum;
  logic              last_pair;

  assign a_sgn = (req_q.fun == FUN_MULH) || (req_q.fun == FUN_MULHSU);
  assign b_sgn = (req_q.fun == FUN_MULH);

  // Operand pair selection for the partial product being issued
  always_comb begin
    mx = lo_ext(req_q.a);
    my = lo_ext(req_q.b);
    case (k_q)
      2'd0: begin mx = lo_ext(req_q.a);        my = lo_ext(req_q.b);        end
      2'd1: begin mx = lo_ext(req_q.a);        my = hi_ext(req_q.b, b_sgn); end
      2'd2: begin mx = hi_ext(req_q.a, a_sgn); my = lo_ext(req_q.b);        end
      default: begin mx = hi_ext(req_q.a, a_sgn); my = hi_ext(req_q.b, b_sgn); end
    endcase
  end

  urv_mult18x18 u_mult (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ce_i  (~stall_i),
    .x_i   (mx),
    .y_i   (my),
    .q_o   (prod)
  );

  // Next-state, accumulation and output logic
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    req_d     = req_q;
    acc_d     = acc_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = done_q;
    // Product in the register belongs to the pair issued one cycle earlier
    sum       = acc_q + pp_align(prod, k_q - 2'd1);
    last_pair = (k_q == 2'd3) ||
                ((k_q == 2'd2) && (g_fast_mul_lo != 0) && (req_q.fun == FUN_MUL));

    if (abort_i) begin
      state_d = ST_IDLE;
      k_d     = 2'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (!stall_i) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            req_d.fun = fun_t'(fun_i);
            req_d.a   = rs1_i;
            req_d.b   = rs2_i;
            acc_d     = '0;
            k_d       = 2'd0;
            busy_d    = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (k_q != 2'd0) begin
            acc_d = sum;
          end
          k_d = k_q + 2'd1;
          if (last_pair) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          acc_d    = sum;
          result_d = (req_q.fun == FUN_MUL) ? sum[XLEN-1:0] : sum[ACCW-1:XLEN];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          k_d      = 2'd0;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= 2'd0;
      req_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      req_q    <= req_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
